// File: rtl/rs232_tx.sv
// rtl/rs232_tx.sv - 8N1 serial transmitter with a small transmit FIFO
module rs232_tx #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          TX,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // Clocks per serial bit, truncated toward zero
    localparam int PERIOD = CLK_HZ / BAUD;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Reject parameter sets the counters and FIFO pointers cannot represent
    generate
        if (PERIOD < 2) begin : g_bad_period
            $error("rs232_tx: CLK_HZ / BAUD must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("rs232_tx: FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [7:0]       fifo_head;

    // Ready depends only on the registered occupancy so upstream sees no
    // combinational path from its own valid or from this cycle's pop.
    assign tx_ready   = (fifo_level != LVL_FULL);
    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_head  = mem[rd_ptr];

    // Storage array; contents need no reset because the level gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks push/pop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_nx;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nx;
    logic             tx_q;
    logic             tx_nx;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_LAST);

    // State register plus the datapath registers it steers; TX comes straight from tx_q
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= cnt_nx;
            bit_idx  <= bit_nx;
            shreg    <= shreg_nx;
            tx_q     <= tx_nx;
        end
    end

    // Next state: each non-idle state lasts one bit time, DATA lasts eight
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_nx = fifo_empty ? S_IDLE : S_START;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs: FIFO pop plus next values for counter, bit index, shifter and line
    always_comb begin
        pop      = 1'b0;
        cnt_nx   = baud_cnt + CNT_ONE;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        tx_nx    = tx_q;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                tx_nx  = 1'b1;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shreg_nx = fifo_head;
                    tx_nx    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_nx = '0;
                    bit_nx = '0;
                    tx_nx  = shreg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_nx = '0;
                    if (bit_idx == 3'd7) begin
                        bit_nx = '0;
                        tx_nx  = 1'b1;
                    end else begin
                        bit_nx   = bit_idx + 3'd1;
                        shreg_nx = {1'b0, shreg[7:1]};
                        tx_nx    = shreg[1];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_nx = '0;
                    tx_nx  = 1'b1;
                    // Chain straight into the next start bit when more data waits
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shreg_nx = fifo_head;
                        tx_nx    = 1'b0;
                    end
                end
            end
            default: begin
                cnt_nx = '0;
                bit_nx = '0;
                tx_nx  = 1'b1;
            end
        endcase
    end

    assign TX   = tx_q;
    assign busy = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_rs232_tx.sv
// tb/tb_rs232_tx.sv - self-checking bench for rs232_tx
module tb_rs232_tx;

    localparam int PA = 12000000 / 9600;
    localparam int PB = 16 / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn_a, resetn_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b;
    logic       rdy_a, rdy_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;
    logic [2:0] lvl_a, lvl_b;

    rs232_tx dut_a (
        .clk        (clk),
        .resetn     (resetn_a),
        .tx_data    (tx_data_a),
        .tx_valid   (tx_valid_a),
        .tx_ready   (rdy_a),
        .TX         (tx_a),
        .busy       (busy_a),
        .fifo_level (lvl_a)
    );

    rs232_tx #(.CLK_HZ(16), .BAUD(4), .FIFO_DEPTH(4)) dut_b (
        .clk        (clk),
        .resetn     (resetn_b),
        .tx_data    (tx_data_b),
        .tx_valid   (tx_valid_b),
        .tx_ready   (rdy_b),
        .TX         (tx_b),
        .busy       (busy_b),
        .fifo_level (lvl_b)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Trace recorder: one sample 1 time unit after every rising edge
    logic rec_on  = 1'b0;
    logic rec_sel = 1'b0;
    logic rec_tx[$];
    logic rec_busy[$];
    logic rec_rdy[$];
    int   rec_lvl[$];
    logic [7:0] rx_bytes[$];
    logic       rx_stop[$];

    always @(posedge clk) begin
        #1;
        if (rec_on) begin
            rec_tx.push_back(rec_sel ? tx_b : tx_a);
            rec_busy.push_back(rec_sel ? busy_b : busy_a);
            rec_rdy.push_back(rec_sel ? rdy_b : rdy_a);
            rec_lvl.push_back(rec_sel ? int'(lvl_b) : int'(lvl_a));
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic tx_at(input int i);
        return (i >= 0 && i < rec_tx.size()) ? rec_tx[i] : 1'bx;
    endfunction
    function automatic logic busy_at(input int i);
        return (i >= 0 && i < rec_busy.size()) ? rec_busy[i] : 1'bx;
    endfunction
    function automatic int lvl_at(input int i);
        return (i >= 0 && i < rec_lvl.size()) ? rec_lvl[i] : -1;
    endfunction

    // Line level of 8N1 bit cell c (0 = start, 1..8 = data LSB first, 9 = stop)
    function automatic logic frame_bit(input logic [7:0] b, input int c);
        if (c == 0) return 1'b0;
        if (c == 9) return 1'b1;
        return b[c-1];
    endfunction

    task automatic clear_rec();
        rec_tx.delete();
        rec_busy.delete();
        rec_rdy.delete();
        rec_lvl.delete();
    endtask

    // Every bit cell must hold its level for exactly p samples, frames back to back
    task automatic check_frames(input string tag, input int p, input int first, input logic [7:0] bytes[$]);
        int base;
        int hits;
        for (int f = 0; f < bytes.size(); f++) begin
            for (int c = 0; c < 10; c++) begin
                base = first + (f * 10 + c) * p;
                hits = 0;
                for (int k = 0; k < p; k++)
                    if (tx_at(base + k) === frame_bit(bytes[f], c)) hits++;
                check($sformatf("%s_f%0d_cell%0d", tag, f, c), hits, p);
            end
        end
        check({tag, "_idle_after"}, tx_at(first + bytes.size() * 10 * p), 1'b1);
    endtask

    // Receiver model: find the falling edge, then sample in the middle of each bit
    task automatic uart_rx(input int p);
        int i;
        int mid;
        logic [7:0] b;
        rx_bytes.delete();
        rx_stop.delete();
        i = 0;
        while (i < rec_tx.size()) begin
            if (rec_tx[i] === 1'b0) begin
                mid = i + p / 2;
                if (mid + 9 * p >= rec_tx.size()) break;
                for (int k = 0; k < 8; k++) b[k] = rec_tx[mid + (k + 1) * p];
                rx_bytes.push_back(b);
                rx_stop.push_back(rec_tx[mid + 9 * p]);
                i = mid + 9 * p + 1;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        logic [7:0] one_q[$];
        logic [7:0] burst_q[$];
        logic [7:0] exp_q[$];
        int         acc[$];
        int         n0;
        int         cnt;
        int         mx;
        logic       accept;

        resetn_a = 1'b0; resetn_b = 1'b0;
        tx_valid_a = 1'b0; tx_valid_b = 1'b0;
        tx_data_a = 8'h00; tx_data_b = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        check("rst_tx_a", tx_a, 1'b1);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_lvl_a", lvl_a, 0);
        check("rst_rdy_a", rdy_a, 1'b1);
        check("rst_tx_b", tx_b, 1'b1);
        check("rst_busy_b", busy_b, 1'b0);
        check("rst_lvl_b", lvl_b, 0);
        check("rst_rdy_b", rdy_b, 1'b1);

        // Default parameters: single byte 0x31, accepted on the first edge after reset release
        clear_rec();
        rec_sel = 1'b0;
        resetn_a = 1'b1;
        tx_valid_a = 1'b1;
        tx_data_a = 8'h31;
        rec_on = 1'b1;
        @(negedge clk);
        check("a_first_edge_accept_lvl", lvl_a, 1);
        tx_valid_a = 1'b0;
        tx_data_a = 8'hFF;
        for (int t = 0; t < 10 * PA + 20 && rec_tx.size() < 10 * PA + 4; t++) @(negedge clk);
        rec_on = 1'b0;
        check("a_no_early_start", tx_at(0), 1'b1);
        one_q = {8'h31};
        check_frames("a31", PA, 1, one_q);
        check("a_busy_last_stop", busy_at(10 * PA), 1'b1);
        check("a_busy_drop", busy_at(10 * PA + 1), 1'b0);

        // PERIOD=4 instance: 0xA5 frame exactly 40 clocks, decoded mid-bit
        clear_rec();
        rec_sel = 1'b1;
        resetn_b = 1'b1;
        tx_valid_b = 1'b1;
        tx_data_b = 8'hA5;
        rec_on = 1'b1;
        @(negedge clk);
        tx_valid_b = 1'b0;
        for (int t = 0; t < 10 * PB + 20 && rec_tx.size() < 10 * PB + 4; t++) @(negedge clk);
        rec_on = 1'b0;
        one_q = {8'hA5};
        check("b_a5_no_early_start", tx_at(0), 1'b1);
        check_frames("bA5", PB, 1, one_q);
        uart_rx(PB);
        check("bA5_rx_count", rx_bytes.size(), 1);
        check("bA5_rx_byte", (rx_bytes.size() > 0) ? rx_bytes[0] : 8'hxx, 8'hA5);

        // Burst of six on consecutive edges; sixth is held valid while the FIFO is full
        @(negedge clk);
        clear_rec();
        burst_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        acc.delete();
        tx_valid_b = 1'b1;
        tx_data_b = burst_q[0];
        rec_on = 1'b1;
        for (int t = 0; t < 400 && acc.size() < 6; t++) begin
            accept = tx_valid_b && rdy_b;
            @(negedge clk);
            if (accept) begin
                acc.push_back(cyc);
                if (acc.size() < 6) tx_data_b = burst_q[acc.size()];
                else begin
                    tx_valid_b = 1'b0;
                    tx_data_b = 8'h00;
                end
            end
        end
        check("burst_accept_count", acc.size(), 6);
        for (int k = 1; k < 5; k++)
            check($sformatf("burst_accept_edge%0d", k), (acc.size() > k) ? acc[k] - acc[0] : -1, k);
        check("burst_sixth_stall", (acc.size() > 5) ? acc[5] - acc[0] : -1, 10 * PB + 2);
        for (int t = 0; t < 80 * PB && rec_tx.size() < 60 * PB + 4; t++) @(negedge clk);
        rec_on = 1'b0;
        check("burst_rdy_low_after5", (rec_rdy.size() > 4) ? rec_rdy[4] : 1'bx, 1'b0);
        check("burst_lvl_full", lvl_at(4), 4);
        check("burst_lvl_before_pop", lvl_at(10 * PB), 4);
        check("burst_lvl_after_pop", lvl_at(10 * PB + 1), 3);
        check("burst_lvl_refill", lvl_at(10 * PB + 2), 4);
        check_frames("burst", PB, 1, burst_q);
        check("burst_busy_end", busy_at(60 * PB), 1'b1);
        check("burst_busy_drop", busy_at(60 * PB + 1), 1'b0);
        uart_rx(PB);
        check("burst_rx_count", rx_bytes.size(), 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("burst_rx_byte%0d", k), (rx_bytes.size() > k) ? rx_bytes[k] : 8'hxx, burst_q[k]);

        // Reset during bit 3 of 0x55 with two more bytes queued
        @(negedge clk);
        tx_valid_b = 1'b1;
        tx_data_b = 8'h55;
        @(negedge clk);
        n0 = cyc;
        tx_data_b = 8'($urandom);
        @(negedge clk);
        tx_data_b = 8'($urandom);
        @(negedge clk);
        tx_valid_b = 1'b0;
        while (cyc < n0 + 2 + 4 * PB) @(negedge clk);
        check("rst_mid_pre_tx", tx_b, frame_bit(8'h55, 4));
        check("rst_mid_pre_lvl", lvl_b, 2);
        resetn_b = 1'b0;
        #2;
        check("rst_mid_async_tx", tx_b, 1'b1);
        check("rst_mid_async_lvl", lvl_b, 0);
        check("rst_mid_async_busy", busy_b, 1'b0);
        check("rst_mid_async_rdy", rdy_b, 1'b1);
        @(negedge clk);
        resetn_b = 1'b1;
        clear_rec();
        rec_on = 1'b1;
        repeat (15 * PB) @(negedge clk);
        rec_on = 1'b0;
        cnt = 0;
        for (int i = 0; i < rec_tx.size(); i++)
            if (rec_tx[i] === 1'b1 && rec_busy[i] === 1'b0 && rec_lvl[i] == 0) cnt++;
        check("rst_mid_quiet_after", cnt, 15 * PB);

        // Randomized traffic with random valid gaps, compared through the receiver model
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            clear_rec();
            exp_q.delete();
            rec_on = 1'b1;
            for (int t = 0; t < 60; t++) begin
                tx_valid_b = ($urandom_range(0, 3) != 0);
                tx_data_b = 8'($urandom);
                accept = tx_valid_b && rdy_b;
                @(negedge clk);
                if (accept) exp_q.push_back(tx_data_b);
            end
            tx_valid_b = 1'b0;
            for (int t = 0; t < 20 * 10 * PB && busy_b; t++) @(negedge clk);
            check($sformatf("rand%0d_drained", r), busy_b, 1'b0);
            repeat (2) @(negedge clk);
            rec_on = 1'b0;
            uart_rx(PB);
            check($sformatf("rand%0d_rx_count", r), rx_bytes.size(), exp_q.size());
            for (int k = 0; k < exp_q.size(); k++) begin
                check($sformatf("rand%0d_rx_byte%0d", r, k), (rx_bytes.size() > k) ? rx_bytes[k] : 8'hxx, exp_q[k]);
                check($sformatf("rand%0d_stop%0d", r, k), (rx_stop.size() > k) ? rx_stop[k] : 1'bx, 1'b1);
            end
            mx = 0;
            for (int i = 0; i < rec_lvl.size(); i++) if (rec_lvl[i] > mx) mx = rec_lvl[i];
            check($sformatf("rand%0d_lvl_max_in_range", r), (mx <= 4) ? 1 : 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
